// File: rtl/variance_pkg.sv
// Shared constants, FSM state encoding and a floor-log2 helper for the variance unit.
package variance_pkg;

  localparam int VAR_DATA_WIDTH  = 8;
  localparam int VAR_MAX_SAMPLES = 64;
  localparam int VAR_ADDR_WIDTH  = $clog2(VAR_MAX_SAMPLES);
  localparam int VAR_ACC_WIDTH   = 2 * VAR_DATA_WIDTH + VAR_ADDR_WIDTH;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_COLLECT   = 3'd1,
    ST_WAIT_MEAN = 3'd2,
    ST_ACCUM     = 3'd3,
    ST_DONE      = 3'd4
  } state_t;

  function automatic int flog2(input int v);
    int r;
    r = 0;
    for (int i = 1; i < 31; i++) begin
      if (v >= (1 << i)) r = i;
    end
    return r;
  endfunction

endpackage

// File: rtl/sample_buffer.sv
// Single-port-write / single-port-read sample store with a registered read.
module sample_buffer
  import variance_pkg::*;
#(
  parameter int DATA_WIDTH = VAR_DATA_WIDTH,
  parameter int DEPTH      = VAR_MAX_SAMPLES,
  parameter int ADDR_WIDTH = VAR_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/variance_unit.sv
// Population variance of a buffered sample block against an externally supplied mean.
// Build option VARIANCE_ROUND_EN: final divide rounds half-up instead of flooring.
//
// state      | meaning
// IDLE       | waiting for start_data_in
// COLLECT    | capturing en-qualified samples into the buffer
// WAIT_MEAN  | all N samples held, waiting for a mean
// ACCUM      | N buffer reads plus two pipeline drain cycles
// DONE       | variance_out updated, ready pulsed
module variance_unit
  import variance_pkg::*;
#(
  parameter int DATA_WIDTH  = VAR_DATA_WIDTH,
  parameter int MAX_SAMPLES = VAR_MAX_SAMPLES
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [15:0]             total_samples,
  input  logic [DATA_WIDTH-1:0]   data_in,
  input  logic                    start_data_in,
  input  logic                    en,
  input  logic [DATA_WIDTH-1:0]   mean_in,
  input  logic                    mean_valid,
  output logic [2*DATA_WIDTH-1:0] variance_out,
  output logic                    ready,
  output logic                    busy,
  output logic                    overrun
);

  localparam int AW  = $clog2(MAX_SAMPLES);
  localparam int CW  = AW + 1;
  localparam int ACW = 2 * DATA_WIDTH + AW;
  localparam int SW  = $clog2(CW);

  state_t                  state, state_nxt;
  logic [CW-1:0]           cnt, n_reg, n_start, acc_cnt;
  logic [SW-1:0]           shift_reg;
  logic [DATA_WIDTH-1:0]   mean_reg;
  logic                    mean_have;
  logic [ACW-1:0]          acc, acc_sum, acc_adj;
  logic [DATA_WIDTH-1:0]   rd_data, diff;
  logic [2*DATA_WIDTH-1:0] sq_reg;
  logic                    rd_valid, sq_valid;
  logic                    restart, wr_en, rd_en, finish;

  sample_buffer #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (MAX_SAMPLES),
    .ADDR_WIDTH (AW)
  ) u_buf (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (cnt[AW-1:0]),
    .wr_data (data_in),
    .rd_en   (rd_en),
    .rd_addr (acc_cnt[AW-1:0]),
    .rd_data (rd_data)
  );

  always_comb begin
    if (total_samples > 16'(MAX_SAMPLES))  n_start = CW'(MAX_SAMPLES);
    else if (total_samples == 16'd0)       n_start = CW'(1);
    else                                   n_start = total_samples[CW-1:0];
  end

  // |sample - mean| squares to the same value as the signed difference.
  assign diff    = (rd_data >= mean_reg) ? rd_data - mean_reg : mean_reg - rd_data;
  assign acc_sum = acc + ACW'(sq_reg);

`ifdef VARIANCE_ROUND_EN
  assign acc_adj = (shift_reg != '0) ? acc_sum + (ACW'(1) << (shift_reg - 1'b1)) : acc_sum;
`else
  assign acc_adj = acc_sum;
`endif

  assign ready = (state == ST_DONE);
  assign busy  = (state != ST_IDLE);

  always_comb begin
    state_nxt = state;
    restart   = 1'b0;
    wr_en     = 1'b0;
    rd_en     = 1'b0;
    finish    = 1'b0;
    overrun   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start_data_in) begin
          restart   = 1'b1;
          state_nxt = ST_COLLECT;
        end
      end
      ST_COLLECT: begin
        if (start_data_in) begin
          restart = 1'b1;
        end else if (en) begin
          wr_en = 1'b1;
          if (cnt + 1'b1 == n_reg)
            state_nxt = mean_valid ? ST_ACCUM : ST_WAIT_MEAN;
        end
      end
      ST_WAIT_MEAN: begin
        if (start_data_in) begin
          restart   = 1'b1;
          state_nxt = ST_COLLECT;
        end else if (mean_have || mean_valid) begin
          state_nxt = ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        overrun = start_data_in;
        rd_en   = (acc_cnt < n_reg);
        if (acc_cnt == n_reg + 1'b1) begin
          finish    = 1'b1;
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        overrun   = start_data_in;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      n_reg        <= CW'(1);
      shift_reg    <= '0;
      mean_reg     <= '0;
      mean_have    <= 1'b0;
      acc          <= '0;
      acc_cnt      <= '0;
      rd_valid     <= 1'b0;
      sq_valid     <= 1'b0;
      sq_reg       <= '0;
      variance_out <= '0;
    end else begin
      state <= state_nxt;

      if (restart) begin
        cnt       <= '0;
        n_reg     <= n_start;
        shift_reg <= SW'(flog2(int'(n_start)));
        mean_reg  <= '0;
        mean_have <= 1'b0;
      end else begin
        if (wr_en) cnt <= cnt + 1'b1;
        if (mean_valid && (state == ST_COLLECT || state == ST_WAIT_MEAN)) begin
          mean_reg  <= mean_in;
          mean_have <= 1'b1;
        end
      end

      // Pipeline: read -> registered data -> registered square -> accumulate.
      rd_valid <= rd_en;
      sq_valid <= rd_valid;
      sq_reg   <= diff * diff;

      if (state_nxt == ST_ACCUM && state != ST_ACCUM) begin
        acc     <= '0;
        acc_cnt <= '0;
      end else begin
        if (state == ST_ACCUM) acc_cnt <= acc_cnt + 1'b1;
        if (sq_valid)          acc     <= acc_sum;
      end

      if (finish) variance_out <= (2*DATA_WIDTH)'(acc_adj >> shift_reg);
    end
  end

endmodule

// File: tb/tb_variance_unit.sv
// Self-checking bench for variance_unit: directed scenarios plus randomized blocks vs. an arithmetic model.
module tb_variance_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] total_samples;
  logic [7:0]  data_in;
  logic        start_data_in;
  logic        en;
  logic [7:0]  mean_in;
  logic        mean_valid;
  logic [15:0] variance_out;
  logic        ready;
  logic        busy;
  logic        overrun;

  int checks   = 0;
  int failures = 0;

  int stim_data[$];
  bit stim_en[$];

  variance_unit dut (
    .clk           (clk),
    .rst           (rst),
    .total_samples (total_samples),
    .data_in       (data_in),
    .start_data_in (start_data_in),
    .en            (en),
    .mean_in       (mean_in),
    .mean_valid    (mean_valid),
    .variance_out  (variance_out),
    .ready         (ready),
    .busy          (busy),
    .overrun       (overrun)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: population variance over the first N accepted samples, shift by floor(log2 N).
  function automatic int model_var(input int ts, input int mean);
    int n, sh, acc, cnt;
    n   = (ts > 64) ? 64 : ((ts == 0) ? 1 : ts);
    acc = 0;
    cnt = 0;
    foreach (stim_data[i]) begin
      if (stim_en[i] && cnt < n) begin
        acc += (stim_data[i] - mean) * (stim_data[i] - mean);
        cnt++;
      end
    end
    sh = 0;
    while ((2 << sh) <= n) sh++;
`ifdef VARIANCE_ROUND_EN
    if (sh > 0) acc += 1 << (sh - 1);
`endif
    return acc >> sh;
  endfunction

  // lat counts clock edges from the edge that captured the last stimulus entry to ready.
  task automatic run_block(input int ts, input int mean, input int mean_at,
                           input bit wait_rdy, output int lat);
    start_data_in = 1'b1;
    total_samples = ts[15:0];
    tick();
    start_data_in = 1'b0;
    for (int i = 0; i < stim_data.size(); i++) begin
      data_in    = 8'(stim_data[i]);
      en         = stim_en[i];
      mean_in    = 8'(mean);
      mean_valid = (i == mean_at);
      tick();
    end
    en         = 1'b0;
    mean_in    = 8'(mean);
    mean_valid = (mean_at < 0);
    tick();
    mean_valid = 1'b0;
    lat = 1;
    if (wait_rdy) begin
      while (!ready && lat < 400) begin
        tick();
        lat++;
      end
    end
  endtask

  task automatic load_ramp();
    stim_data.delete();
    stim_en.delete();
    for (int i = 1; i <= 64; i++) begin
      stim_data.push_back(i);
      stim_en.push_back(1'b1);
    end
  endtask

  task automatic load_const(input int v, input int n);
    stim_data.delete();
    stim_en.delete();
    for (int i = 0; i < n; i++) begin
      stim_data.push_back(v);
      stim_en.push_back(1'b1);
    end
  endtask

  task automatic test_reset();
    rst           = 1'b1;
    total_samples = '0;
    data_in       = '0;
    start_data_in = 1'b0;
    en            = 1'b0;
    mean_in       = '0;
    mean_valid    = 1'b0;
    tick();
    tick();
    checks += 4;
    if (variance_out !== 16'd0) begin failures++; $display("FAIL reset_var got=%0d exp=0", variance_out); end
    if (ready !== 1'b0)         begin failures++; $display("FAIL reset_ready got=%b exp=0", ready); end
    if (busy !== 1'b0)          begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    if (overrun !== 1'b0)       begin failures++; $display("FAIL reset_overrun got=%b exp=0", overrun); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_ramp();
    int lat, exp_v;
`ifdef VARIANCE_ROUND_EN
    exp_v = 342;
`else
    exp_v = 341;
`endif
    load_ramp();
    run_block(64, 32, -1, 1'b1, lat);
    checks += 5;
    if (lat !== 67)                   begin failures++; $display("FAIL ramp_latency got=%0d exp=67", lat); end
    if (variance_out !== 16'(exp_v))  begin failures++; $display("FAIL ramp_var got=%0d exp=%0d", variance_out, exp_v); end
    if (exp_v !== model_var(64, 32))  begin failures++; $display("FAIL ramp_model got=%0d exp=%0d", model_var(64, 32), exp_v); end
    tick();
    if (ready !== 1'b0)               begin failures++; $display("FAIL ramp_ready_pulse got=%b exp=0", ready); end
    if (busy !== 1'b0)                begin failures++; $display("FAIL ramp_idle_busy got=%b exp=0", busy); end
  endtask

  task automatic test_constant();
    int lat, pulses;
    load_const(6, 64);
    run_block(64, 6, -1, 1'b1, lat);
    checks += 3;
    if (variance_out !== 16'd0) begin failures++; $display("FAIL const_var got=%0d exp=0", variance_out); end
    if (lat !== 67)             begin failures++; $display("FAIL const_latency got=%0d exp=67", lat); end
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (ready) pulses++;
    end
    if (pulses !== 0)           begin failures++; $display("FAIL const_extra_ready got=%0d exp=0", pulses); end
  endtask

  task automatic test_sparse();
    int lat;
    stim_data.delete();
    stim_en.delete();
    for (int i = 0; i < 128; i++) begin
      stim_data.push_back(i + 1);
      stim_en.push_back(i % 2 == 1);
    end
    run_block(64, 65, -1, 1'b1, lat);
    checks += 2;
    if (variance_out !== 16'd1365) begin failures++; $display("FAIL sparse_var got=%0d exp=1365", variance_out); end
    if (lat !== 67)                begin failures++; $display("FAIL sparse_latency got=%0d exp=67", lat); end
    tick();
  endtask

  task automatic test_early_mean();
    int lat, exp_v;
    load_ramp();
    exp_v = model_var(64, 32);
    run_block(64, 32, 9, 1'b1, lat);
    checks += 2;
    if (variance_out !== 16'(exp_v)) begin failures++; $display("FAIL early_var got=%0d exp=%0d", variance_out, exp_v); end
    if (lat !== 67)                  begin failures++; $display("FAIL early_latency got=%0d exp=67", lat); end
    tick();
  endtask

  task automatic test_restart();
    int lat;
    // Partial block with a junk mean, then restarted; junk must be discarded.
    start_data_in = 1'b1;
    total_samples = 16'd4;
    tick();
    start_data_in = 1'b0;
    en         = 1'b1;
    data_in    = 8'd200;
    mean_in    = 8'd0;
    mean_valid = 1'b1;
    tick();
    mean_valid = 1'b0;
    tick();
    en = 1'b0;
    stim_data = '{10, 20, 30, 40};
    stim_en   = '{1'b1, 1'b1, 1'b1, 1'b1};
    run_block(4, 25, -1, 1'b1, lat);
    checks += 2;
    if (variance_out !== 16'(model_var(4, 25))) begin failures++; $display("FAIL restart_var got=%0d exp=%0d", variance_out, model_var(4, 25)); end
    if (lat !== 7)                              begin failures++; $display("FAIL restart_latency got=%0d exp=7", lat); end
    tick();
  endtask

  task automatic test_rst_mid_accum();
    int lat, pulses;
    load_ramp();
    run_block(64, 32, -1, 1'b0, lat);
    for (int i = 0; i < 20; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks += 4;
    if (busy !== 1'b0)          begin failures++; $display("FAIL rst_busy got=%b exp=0", busy); end
    if (ready !== 1'b0)         begin failures++; $display("FAIL rst_ready got=%b exp=0", ready); end
    if (variance_out !== 16'd0) begin failures++; $display("FAIL rst_var got=%0d exp=0", variance_out); end
    pulses = 0;
    for (int i = 0; i < 80; i++) begin
      tick();
      if (ready) pulses++;
    end
    if (pulses !== 0)           begin failures++; $display("FAIL rst_stale_ready got=%0d exp=0", pulses); end
    load_const(6, 64);
    run_block(64, 6, -1, 1'b1, lat);
    checks += 2;
    if (variance_out !== 16'd0) begin failures++; $display("FAIL rst_next_var got=%0d exp=0", variance_out); end
    if (lat !== 67)             begin failures++; $display("FAIL rst_next_latency got=%0d exp=67", lat); end
    tick();
  endtask

  task automatic test_overrun();
    int lat, exp_v;
    load_ramp();
    exp_v = model_var(64, 32);
    run_block(64, 32, -1, 1'b0, lat);
    for (int i = 0; i < 10; i++) tick();
    start_data_in = 1'b1;
    #1;
    checks += 4;
    if (overrun !== 1'b1) begin failures++; $display("FAIL overrun_pulse got=%b exp=1", overrun); end
    tick();
    start_data_in = 1'b0;
    #1;
    if (overrun !== 1'b0) begin failures++; $display("FAIL overrun_clear got=%b exp=0", overrun); end
    lat = 0;
    while (!ready && lat < 400) begin
      tick();
      lat++;
    end
    if (variance_out !== 16'(exp_v)) begin failures++; $display("FAIL overrun_var got=%0d exp=%0d", variance_out, exp_v); end
    tick();
    if (busy !== 1'b0)               begin failures++; $display("FAIL overrun_idle got=%b exp=0", busy); end
  endtask

  task automatic test_random();
    int ts_opts[7] = '{0, 1, 3, 5, 17, 64, 100};
    int ts, n, mean, mean_at, lat, exp_lat, exp_v, acc_cnt;
    for (int b = 0; b < 10; b++) begin
      ts   = ts_opts[$urandom_range(0, 6)];
      n    = (ts > 64) ? 64 : ((ts == 0) ? 1 : ts);
      mean = $urandom_range(0, 255);
      stim_data.delete();
      stim_en.delete();
      acc_cnt = 0;
      while (acc_cnt < n) begin
        stim_data.push_back($urandom_range(0, 255));
        stim_en.push_back($urandom_range(0, 3) != 0);
        if (stim_en[stim_en.size() - 1]) acc_cnt++;
      end
      case ($urandom_range(0, 2))
        0:       mean_at = -1;
        1:       mean_at = stim_data.size() - 1;
        default: mean_at = $urandom_range(0, stim_data.size() - 1);
      endcase
      exp_lat = (mean_at == stim_data.size() - 1) ? n + 2 : n + 3;
      exp_v   = model_var(ts, mean);
      run_block(ts, mean, mean_at, 1'b1, lat);
      checks += 2;
      if (variance_out !== 16'(exp_v)) begin failures++; $display("FAIL rand_var blk=%0d ts=%0d got=%0d exp=%0d", b, ts, variance_out, exp_v); end
      if (lat !== exp_lat)             begin failures++; $display("FAIL rand_latency blk=%0d ts=%0d got=%0d exp=%0d", b, ts, lat, exp_lat); end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_constant();
    test_sparse();
    test_early_mean();
    test_restart();
    test_rst_mid_accum();
    test_overrun();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
